muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 217 +++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit -- iterative RV32M-style multiply / divide unit.
//
// One operation at a time. Multiplies use a shift-add loop and divides use a
// restoring loop, both producing one bit per CALC cycle over XLEN cycles.
// Operands are converted to magnitudes on acceptance and the result is sign
// corrected on the way into DONE. Divide-by-zero and the signed overflow case
// (most-negative / -1) skip the loop and finish in a single cycle.
//
// Ports
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   start   in   request a new operation (sampled only in IDLE)
//   funct3  in   000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//                100 DIV, 101 DIVU, 110 REM,  111 REMU
//   op_a    in   rs1 operand / dividend
//   op_b    in   rs2 operand / divisor
//   flush   in   abort the in-flight operation (ignored in DONE)
//   busy    out  high while iterating (CALC)
//   done    out  one-cycle pulse, result valid
//   result  out  last completed result, held until overwritten
//   stall   out  pipeline hold request; low in DONE so result is captured
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            stall
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic                neg_q, neg_d;      // negate result during correction
  logic [2*XLEN-1:0]   acc_q, acc_d;      // product, or {remainder, quotient}
  logic [XLEN-1:0]     opb_q, opb_d;      // multiplicand / divisor magnitude
  logic [XLEN-1:0]     result_q, result_d;

  // ---------------------------------------------------------------------------
  // Operand decode for a new request
  // ---------------------------------------------------------------------------
  logic            signed_a, signed_b, a_neg, b_neg;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_zero, div_ovf, bypass;
  logic [XLEN-1:0] bypass_val;

  always_comb begin
    // MULH, MULHSU, DIV, REM treat rs1 as signed; MULH, DIV, REM treat rs2 so.
    signed_a = (funct3 == 3'b001) || (funct3 == 3'b010) ||
               (funct3 == 3'b100) || (funct3 == 3'b110);
    signed_b = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    a_neg    = signed_a && op_a[XLEN-1];
    b_neg    = signed_b && op_b[XLEN-1];
    mag_a    = a_neg ? -op_a : op_a;
    mag_b    = b_neg ? -op_b : op_b;

    div_zero = funct3[2] && (op_b == '0);
    // Only the signed forms (DIV, REM) can overflow.
    div_ovf  = funct3[2] && !funct3[0] &&
               (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    bypass   = div_zero || div_ovf;

    // REM/REMU: dividend on zero divisor, 0 on overflow.
    // DIV/DIVU: all ones on zero divisor, the dividend (most negative) on overflow.
    if (funct3[1]) bypass_val = div_zero ? op_a : '0;
    else           bypass_val = div_zero ? '1   : op_a;
  end

  // ---------------------------------------------------------------------------
  // One iteration of the datapath
  // ---------------------------------------------------------------------------
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift, div_diff;
  logic [XLEN-1:0]   div_rem;
  logic              div_bit;
  logic [2*XLEN-1:0] acc_step;

  always_comb begin
    // Shift-add: add multiplicand to the upper half when the current
    // multiplier bit (LSB) is set, then shift the whole register right,
    // keeping the carry as the new MSB.
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);

    // Restoring divide: bring the next dividend bit into the partial
    // remainder and subtract the divisor if it fits (no borrow).
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    div_bit   = !div_diff[XLEN];
    div_rem   = div_bit ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];

    if (op_q[2]) acc_step = {div_rem, acc_q[XLEN-2:0], div_bit};
    else         acc_step = {mul_sum, acc_q[XLEN-1:1]};
  end

  // ---------------------------------------------------------------------------
  // Sign correction of the final iteration's value
  // ---------------------------------------------------------------------------
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, final_val;

  always_comb begin
    prod_fix = neg_q ? -acc_step : acc_step;
    quo_fix  = neg_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
    rem_fix  = neg_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
    case (op_q)
      3'b000:                 final_val = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_val = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         final_val = quo_fix;
      default:                final_val = rem_fix;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned here gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          op_d  = funct3;
          // REM takes the dividend's sign; everything else takes the XOR.
          neg_d = (funct3 == 3'b110) ? a_neg : (a_neg ^ b_neg);
          acc_d = {{XLEN{1'b0}}, mag_a};
          opb_d = mag_b;
          cnt_d = CNT_INIT;
          if (bypass) begin
            result_d = bypass_val;
            state_d  = S_DONE;
          end else begin
            state_d  = S_CALC;
          end
        end
      end

      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_q - CNT_LAST;
          if (cnt_q == CNT_LAST) begin
            result_d = final_val;
            state_d  = S_DONE;
          end
        end
      end

      // Flush does not cancel a result that is already being presented.
      S_DONE:  state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      result_q <= result_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy   = (state_q == S_CALC);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign stall  = ((state_q == S_IDLE) && start && !flush) || busy;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit -- self-checking bench for muldiv_unit (XLEN = 32).
// Directed vector table, hand-written flush / reset / ignored-start sequences,
// and randomized operations compared against a 64-bit arithmetic model.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

  localparam int XLEN     = 32;
  localparam int LAT_CALC = XLEN + 1;   // edges from acceptance to DONE, inclusive
  localparam int LAT_BYP  = 1;

  localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010,
                         F_MULHU = 3'b011, F_DIV = 3'b100, F_DIVU = 3'b101,
                         F_REM = 3'b110, F_REMU = 3'b111;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            flush = 1'b0;
  logic [2:0]      funct3 = '0;
  logic [XLEN-1:0] op_a = '0;
  logic [XLEN-1:0] op_b = '0;
  logic            busy, done, stall;
  logic [XLEN-1:0] result;

  int checks   = 0;
  int failures = 0;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result),
    .stall  (stall)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural definition.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, ua, ub, p, q;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (f3)
      F_MUL:    begin p = ua * ub; return p[31:0];  end
      F_MULH:   begin p = sa * sb; return p[63:32]; end
      F_MULHSU: begin p = sa * ub; return p[63:32]; end
      F_MULHU:  begin p = ua * ub; return p[63:32]; end
      F_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        q = sa / sb;
        return q[31:0];
      end
      F_DIVU: begin
        if (b == 0) return 32'hFFFF_FFFF;
        q = ua / ub;
        return q[31:0];
      end
      F_REM: begin
        if (b == 0) return a;
        q = sa % sb;
        return q[31:0];
      end
      default: begin
        if (b == 0) return a;
        q = ua % ub;
        return q[31:0];
      end
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b);
    if (f3[2] && b == 0) return LAT_BYP;
    if ((f3 == F_DIV || f3 == F_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return LAT_BYP;
    return LAT_CALC;
  endfunction

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    funct3 = f3;
    op_a   = a;
    op_b   = b;
    start  = 1'b1;
  endtask

  // Called just before the accepting edge with start already driven.
  // lat counts edges from acceptance (1) to the one entering DONE.
  task automatic collect(input string name, output logic [31:0] res, output int lat,
                         output int bcnt);
    logic stall_bad;
    stall_bad = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 1;
    bcnt  = 0;
    while (!done && lat < 100) begin
      bcnt += int'(busy);
      if (stall !== busy) stall_bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    check({name, " done seen"}, done, 1);
    check({name, " stall tracks busy"}, stall_bad, 0);
    check({name, " stall in DONE"}, stall, 0);
    res = result;
    @(posedge clk); #1;
    check({name, " done one cycle"}, done, 0);
  endtask

  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] res, output int lat,
                        output int bcnt);
    @(negedge clk);
    issue(f3, a, b);
    #1;
    check({name, " stall on request"}, stall, 1);
    collect(name, res, lat, bcnt);
  endtask

  task automatic watch(input int n, output int dn, output int bz);
    dn = 0;
    bz = 0;
    repeat (n) begin
      @(posedge clk); #1;
      dn += int'(done);
      bz += int'(busy);
    end
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      4:       return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  typedef struct {
    string      name;
    logic [2:0] f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int         lat;
  } vec_t;

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin : main
    vec_t        vecs[$];
    logic [31:0] res, held;
    int          lat, bcnt, dn, bz;

    vecs.push_back('{"MUL 7x-3",         F_MUL,    32'h7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT_CALC});
    vecs.push_back('{"MULH min x min",   F_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, LAT_CALC});
    vecs.push_back('{"MULHU -1x-1",      F_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT_CALC});
    vecs.push_back('{"MULHSU -1x-1",     F_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT_CALC});
    vecs.push_back('{"DIV -7/2",         F_DIV,    32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, LAT_CALC});
    vecs.push_back('{"REM -7/2",         F_REM,    32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, LAT_CALC});
    vecs.push_back('{"DIVU 100/7",       F_DIVU,   32'd100,       32'd7,         32'd14,        LAT_CALC});
    vecs.push_back('{"REMU 100/7",       F_REMU,   32'd100,       32'd7,         32'd2,         LAT_CALC});
    vecs.push_back('{"DIVU 5/0",         F_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, LAT_BYP});
    vecs.push_back('{"REM 5/0",          F_REM,    32'd5,         32'd0,         32'd5,         LAT_BYP});
    vecs.push_back('{"DIV 5/0",          F_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, LAT_BYP});
    vecs.push_back('{"REMU 5/0",         F_REMU,   32'd5,         32'd0,         32'd5,         LAT_BYP});
    vecs.push_back('{"DIV ovf",          F_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_BYP});
    vecs.push_back('{"REM ovf",          F_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         LAT_BYP});
    vecs.push_back('{"REMU min/-1",      F_REMU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_CALC});
    vecs.push_back('{"DIV 7/-2",         F_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, LAT_CALC});

    // Reset state, observed without any clock edge having occurred.
    #2;
    check("reset busy",   busy,   0);
    check("reset done",   done,   0);
    check("reset stall",  stall,  0);
    check("reset result", result, 0);

    // First start is accepted on the first rising edge after release.
    @(negedge clk);
    rst_n = 1'b1;
    issue(F_MUL, 32'h7, 32'hFFFF_FFFD);
    #1;
    check("first stall on request", stall, 1);
    collect("first MUL", res, lat, bcnt);
    check("first MUL result",  res,  32'hFFFF_FFEB);
    check("first MUL latency", lat,  LAT_CALC);
    check("first MUL busy",    bcnt, XLEN);

    // Directed table.
    foreach (vecs[i]) begin
      run_op(vecs[i].name, vecs[i].f3, vecs[i].a, vecs[i].b, res, lat, bcnt);
      check({vecs[i].name, " result"},  res,  vecs[i].exp);
      check({vecs[i].name, " latency"}, lat,  vecs[i].lat);
      check({vecs[i].name, " busy"},    bcnt, (vecs[i].lat == LAT_BYP) ? 0 : XLEN);
    end

    // A second start raised while busy is ignored.
    @(negedge clk);
    issue(F_DIVU, 32'd1000, 32'd10);
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 100) begin
      if (lat == 3) issue(F_MUL, 32'd5, 32'd5);
      if (lat == 6) start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    check("ignored start result",  result, 32'd100);
    check("ignored start latency", lat,    LAT_CALC);
    @(posedge clk); #1;
    check("ignored start no re-accept", busy, 0);
    held = result;

    // Flush in CALC cycle 10, with a competing start in the same cycle.
    @(negedge clk);
    issue(F_MUL, 32'd9, 32'd9);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("flush pre busy", busy, 1);
    flush = 1'b1;
    issue(F_DIVU, 32'd50, 32'd5);
    @(posedge clk); #1;
    flush = 1'b0;
    start = 1'b0;
    check("flush busy",  busy,  0);
    check("flush stall", stall, 0);
    watch(40, dn, bz);
    check("flush no done",   dn,     0);
    check("flush no busy",   bz,     0);
    check("flush result held", result, held);

    // Flush together with start in IDLE: nothing accepted.
    @(negedge clk);
    issue(F_DIVU, 32'd7, 32'd1);
    flush = 1'b1;
    #1;
    check("idle flush stall", stall, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    start = 1'b0;
    watch(40, dn, bz);
    check("idle flush no done", dn, 0);
    check("idle flush no busy", bz, 0);
    check("idle flush result",  result, held);

    // Reset mid-CALC: outputs clear without an edge, no stale done afterward.
    @(negedge clk);
    issue(F_MUL, 32'd6, 32'd7);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid reset busy",   busy,   0);
    check("mid reset done",   done,   0);
    check("mid reset stall",  stall,  0);
    check("mid reset result", result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    watch(40, dn, bz);
    check("post reset no done", dn, 0);
    check("post reset no busy", bz, 0);
    run_op("MUL 3x4", F_MUL, 32'd3, 32'd4, res, lat, bcnt);
    check("MUL 3x4 result",  res, 32'd12);
    check("MUL 3x4 latency", lat, LAT_CALC);

    // Randomized operations against the arithmetic model.
    for (int n = 0; n < 150; n++) begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      f3 = 3'($urandom_range(0, 7));
      a  = rand_operand();
      b  = rand_operand();
      run_op($sformatf("rand%0d f3=%0d a=%h b=%h", n, f3, a, b), f3, a, b, res, lat, bcnt);
      check($sformatf("rand%0d result", n),  res, model(f3, a, b));
      check($sformatf("rand%0d latency", n), lat, model_lat(f3, a, b));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
